// File: rtl/ias_program_loader.sv
// Boot loader for the IAS core: streams a program image into the 16x8 memory write port,
// checks the trailing mod-256 checksum, then releases the core's active-high reset.
module ias_program_loader #(
  parameter int ADDR_W      = 4,
  parameter int DATA_W      = 8,
  parameter int DEPTH       = 16,
  parameter int HOLD_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data_in,
  output logic              cpu_reset,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   word_count
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_LOAD    = 3'd1;
  localparam logic [2:0] ST_RELEASE = 3'd2;
  localparam logic [2:0] ST_RUN     = 3'd3;
  localparam logic [2:0] ST_ERROR   = 3'd4;

  localparam int                HOLD_W    = (HOLD_CYCLES < 2) ? 1 : $clog2(HOLD_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES);
  localparam logic [ADDR_W:0]   DEPTH_WC  = (ADDR_W + 1)'(DEPTH);

  logic [2:0]        state_q, state_d;
  logic [DATA_W-1:0] sum_q, sum_d;
  logic [ADDR_W:0]   wc_q, wc_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              cpu_reset_q, cpu_reset_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              error_q, error_d;

  // Next-state decode; mem_we defaults low so each accepted word gives a one-cycle pulse
  always_comb begin
    state_d     = state_q;
    sum_d       = sum_q;
    wc_d        = wc_q;
    hold_d      = hold_q;
    mem_we_d    = 1'b0;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cpu_reset_d = cpu_reset_q;
    busy_d      = busy_q;
    done_d      = done_q;
    error_d     = error_q;
    case (state_q)
      ST_IDLE, ST_RUN, ST_ERROR: begin
        if (start) begin
          state_d     = ST_LOAD;
          sum_d       = {DATA_W{1'b0}};
          wc_d        = {(ADDR_W + 1){1'b0}};
          hold_d      = {HOLD_W{1'b0}};
          cpu_reset_d = 1'b1;
          busy_d      = 1'b1;
          done_d      = 1'b0;
          error_d     = 1'b0;
        end else begin
          state_d = state_q;
        end
      end
      ST_LOAD: begin
        if (!in_valid) begin
          state_d = ST_LOAD;
        end else if (!in_last && (wc_q != DEPTH_WC)) begin
          mem_we_d = 1'b1;
          addr_d   = wc_q[ADDR_W-1:0];
          wdata_d  = in_data;
          sum_d    = sum_q + in_data;
          wc_d     = wc_q + {{ADDR_W{1'b0}}, 1'b1};
        end else if (in_last && (wc_q != {(ADDR_W + 1){1'b0}}) && (in_data == sum_q)) begin
          state_d = ST_RELEASE;
          hold_d  = {HOLD_W{1'b0}};
        end else begin
          // overflow, empty image or checksum mismatch
          state_d     = ST_ERROR;
          error_d     = 1'b1;
          busy_d      = 1'b0;
          cpu_reset_d = 1'b1;
        end
      end
      ST_RELEASE: begin
        if (hold_q == HOLD_LAST) begin
          state_d     = ST_RUN;
          cpu_reset_d = 1'b0;
          done_d      = 1'b1;
          busy_d      = 1'b0;
        end else begin
          hold_d = hold_q + {{(HOLD_W - 1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_d     = ST_IDLE;
        cpu_reset_d = 1'b1;
        busy_d      = 1'b0;
      end
    endcase
  end

  // State and output registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      sum_q       <= {DATA_W{1'b0}};
      wc_q        <= {(ADDR_W + 1){1'b0}};
      hold_q      <= {HOLD_W{1'b0}};
      mem_we_q    <= 1'b0;
      addr_q      <= {ADDR_W{1'b0}};
      wdata_q     <= {DATA_W{1'b0}};
      cpu_reset_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      sum_q       <= sum_d;
      wc_q        <= wc_d;
      hold_q      <= hold_d;
      mem_we_q    <= mem_we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cpu_reset_q <= cpu_reset_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  assign in_ready    = (state_q == ST_LOAD);
  assign mem_we      = mem_we_q;
  assign mem_address = addr_q;
  assign mem_data_in = wdata_q;
  assign cpu_reset   = cpu_reset_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign error       = error_q;
  assign word_count  = wc_q;

endmodule
